// File: rtl/debounced_bcd_counter.sv
// debounced_bcd_counter: two debounced push-buttons stepping a wrapping 00-99 BCD counter.
// Each button path is synchroniser -> stable-level filter -> registered press edge.
module debounced_bcd_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_up_i,
    input  logic       btn_dn_i,
    input  logic       clear_i,
    output logic [3:0] ones_o,
    output logic [3:0] tens_o,
    output logic       wrap_o
);
    localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);
    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d, prev_q, prev_d, step_q, step_d;
    logic [1:0][19:0] cnt_q, cnt_d;
    logic [3:0]       ones_q, ones_d, tens_q, tens_d;
    logic             wrap_q, wrap_d;
    always_comb begin
        sync1_d = {btn_dn_i, btn_up_i};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_MAX) deb_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
        prev_d = deb_q;
        step_d = deb_q & ~prev_q;
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        // Coincident up and down steps cancel and fall through unchanged.
        if (clear_i) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (step_q == 2'b01) begin
            ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
            tens_d = (ones_q != 4'd9) ? tens_q : (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            wrap_d = (ones_q == 4'd9) && (tens_q == 4'd9);
        end else if (step_q == 2'b10) begin
            ones_d = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
            tens_d = (ones_q != 4'd0) ? tens_q : (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            wrap_d = (ones_q == 4'd0) && (tens_q == 4'd0);
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            prev_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            prev_q  <= prev_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            wrap_q  <= wrap_d;
        end
    end
    assign ones_o = ones_q;
    assign tens_o = tens_q;
    assign wrap_o = wrap_q;
endmodule

// File: tb/tb_debounced_bcd_counter.sv
// tb_debounced_bcd_counter: directed table, corner sequences and random bouncing buttons
// against a window-based reference model of the debounced counter.
module tb_debounced_bcd_counter;
    localparam int DEB = 4;
    logic       clk_i = 1'b0, rst_n_i = 1'b0;
    logic       btn_up_i = 1'b0, btn_dn_i = 1'b0, clear_i = 1'b0;
    logic [3:0] ones_o, tens_o;
    logic       wrap_o;
    int total = 0, bad = 0;
    int mv;
    bit mw;
    bit hist [2][DEB+2];
    bit stab [2];
    bit [1:0] pipe [2];
    typedef struct { bit up; bit dn; bit clr; int hold; int val; bit wrap; } vec_t;
    vec_t tbl [$];

    debounced_bcd_counter #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .btn_up_i(btn_up_i), .btn_dn_i(btn_dn_i),
        .clear_i(clear_i), .ones_o(ones_o), .tens_o(tens_o), .wrap_o(wrap_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int val();
        return int'(tens_o) * 10 + int'(ones_o);
    endfunction

    function automatic void add(bit up, bit dn, bit clr, int hold, int v, bit w);
        vec_t e;
        e.up = up; e.dn = dn; e.clr = clr; e.hold = hold; e.val = v; e.wrap = w;
        tbl.push_back(e);
    endfunction

    function automatic void model_reset();
        mv = 0;
        mw = 0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DEB + 2; i++) hist[b][i] = 0;
            stab[b] = 0;
            pipe[b] = 2'b00;
        end
    endfunction

    // Stable level flips once the last DEB samples seen by the filter (two edges old)
    // all disagree with it; a rising flip reaches the count two edges later.
    function automatic void model_edge(bit up, bit dn, bit clr);
        bit [1:0] rise, ev;
        bit raw [2];
        raw[0] = up;
        raw[1] = dn;
        for (int b = 0; b < 2; b++) begin
            bit flip;
            for (int i = 0; i < DEB + 1; i++) hist[b][i] = hist[b][i+1];
            hist[b][DEB+1] = raw[b];
            flip = 1;
            for (int i = 0; i < DEB; i++) if (hist[b][i] == stab[b]) flip = 0;
            rise[b] = flip && !stab[b];
            if (flip) stab[b] = !stab[b];
        end
        ev = pipe[0];
        pipe[0] = pipe[1];
        pipe[1] = rise;
        mw = 0;
        if (clr) mv = 0;
        else if (ev == 2'b01) begin mw = (mv == 99); mv = (mv + 1) % 100; end
        else if (ev == 2'b10) begin mw = (mv == 0); mv = (mv + 99) % 100; end
    endfunction

    task automatic cyc(bit up, bit dn, bit clr);
        btn_up_i = up;
        btn_dn_i = dn;
        clear_i  = clr;
        @(posedge clk_i);
        if (rst_n_i) model_edge(up, dn, clr);
        @(negedge clk_i);
        chk("model_ones", int'(ones_o), mv % 10);
        chk("model_tens", int'(tens_o), mv / 10);
        chk("model_wrap", int'(wrap_o), int'(mw));
    endtask

    initial begin
        model_reset();
        add(0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 99; i++) begin add(1, 0, 0, 8, i, 0); add(0, 0, 0, 8, i, 0); end
        add(1, 0, 0, 8, 0, 1);  add(0, 0, 0, 8, 0, 0);
        add(0, 1, 0, 8, 99, 1); add(0, 0, 0, 8, 99, 0);
        add(0, 1, 0, 8, 98, 0); add(0, 0, 0, 8, 98, 0);
        add(0, 0, 1, 1, 0, 0);
        for (int i = 1; i <= 42; i++) begin add(1, 0, 0, 8, i, 0); add(0, 0, 0, 8, i, 0); end
        add(1, 1, 0, 8, 42, 0); add(0, 0, 0, 8, 42, 0);
        add(1, 0, 0, 7, 42, 0); add(1, 0, 1, 1, 0, 0); add(0, 0, 0, 8, 0, 0);

        repeat (3) @(negedge clk_i);
        chk("reset_ones", int'(ones_o), 0);
        chk("reset_tens", int'(tens_o), 0);
        chk("reset_wrap", int'(wrap_o), 0);
        rst_n_i = 1'b1;

        for (int k = 1; k <= 20; k++) begin
            cyc(1, 0, 0);
            chk("clean_ones", int'(ones_o), (k >= 8) ? 1 : 0);
            chk("clean_tens", int'(tens_o), 0);
            chk("clean_wrap", int'(wrap_o), 0);
        end
        repeat (8) cyc(0, 0, 0);

        for (int k = 0; k < 20; k++) cyc((k >= 10) || ((k / 2) % 2 == 0), 0, 0);
        repeat (8) cyc(0, 0, 0);
        chk("bounce_val", val(), 2);

        repeat (3) cyc(1, 0, 0);
        rst_n_i = 1'b0;
        model_reset();
        #1;
        chk("async_rst_val", val(), 0);
        repeat (2) cyc(1, 0, 0);
        chk("in_rst_val", val(), 0);
        rst_n_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1, 0, 0);
            chk("held_rst_val", val(), (k >= 8) ? 1 : 0);
        end
        repeat (8) cyc(0, 0, 0);

        foreach (tbl[n]) begin
            repeat (tbl[n].hold) cyc(tbl[n].up, tbl[n].dn, tbl[n].clr);
            chk("tbl_val", val(), tbl[n].val);
            chk("tbl_wrap", int'(wrap_o), int'(tbl[n].wrap));
        end

        for (int n = 0; n < 400; n++) begin
            bit up, dn, clr;
            int len;
            up  = 1'($urandom_range(0, 1));
            dn  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 40) == 0);
            len = (n % 3 == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            for (int k = 0; k < len; k++) cyc(up, dn, clr && (k == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
